// File: rtl/decred_pkg.sv
// decred_pkg
//   Shared constants and types for the decred result-collection path:
//   default macro count, default nonce base address, read-address width,
//   controller state encoding and a helper for the macro-id field width.
package decred_pkg;

  localparam int NUMBER_OF_MACROS = 4;
  localparam int HASH_ADDR_W      = 6;
  localparam logic [HASH_ADDR_W-1:0] NONCE_BASE_ADDR_DEFAULT = 6'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_READ = 2'd2,
    ST_PUSH = 2'd3
  } state_e;

  // Width of the macro-id tag; a single macro still gets a 1-bit tag.
  function automatic int mid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decred_result_fifo.sv
// decred_result_fifo
//   Synchronous FIFO with occupancy count. The head is presented as a
//   valid/data pair; data reads as zero while empty.
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   i_push, i_data    write strobe and word (caller guarantees not full)
//   i_pop             remove head (ignored while empty)
//   o_valid, o_data   head valid flag and head word
//   o_count           number of stored entries (0..DEPTH)
module decred_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign w_pop   = i_pop & (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/decred_result_collector.sv
// decred_result_collector
//   Round-robin collector that scans DATA_AVAILABLE of NUM_MACROS hash
//   macros, reads NONCE_BYTES nonce bytes from each reporting macro over the
//   shared read bus and queues {macro_id, nonce} for the controller.
// Ports:
//   CLK, RESET_N        macro clock, asynchronous active-low reset
//   ENABLE              scanning permitted
//   MACRO_MASK          1 = macro excluded from scanning
//   DATA_AVAILABLE      per-macro result-ready flags
//   MACRO_RD_SELECT     registered one-hot read select (0 outside reads)
//   HASH_ADDR           registered read address (holds outside reads)
//   DATA_FROM_HASH      read data, valid one cycle after its address
//   RESULT_VALID/READY  result handshake, RESULT_DATA = {macro_id, nonce}
//   IRQ                 level, result queue non-empty
//   BUSY                controller not idle
//   RESULT_COUNT        saturating count of queued results since reset
module decred_result_collector
  import decred_pkg::*;
#(
  parameter int                      NUM_MACROS      = NUMBER_OF_MACROS,
  parameter int                      NONCE_BYTES     = 4,
  parameter logic [HASH_ADDR_W-1:0]  NONCE_BASE_ADDR = NONCE_BASE_ADDR_DEFAULT,
  parameter int                      FIFO_DEPTH      = 4
) (
  input  logic                                            CLK,
  input  logic                                            RESET_N,
  input  logic                                            ENABLE,
  input  logic [NUM_MACROS-1:0]                           MACRO_MASK,
  input  logic [NUM_MACROS-1:0]                           DATA_AVAILABLE,
  output logic [NUM_MACROS-1:0]                           MACRO_RD_SELECT,
  output logic [HASH_ADDR_W-1:0]                          HASH_ADDR,
  input  logic [7:0]                                      DATA_FROM_HASH,
  output logic                                            RESULT_VALID,
  input  logic                                            RESULT_READY,
  output logic [mid_width(NUM_MACROS)+8*NONCE_BYTES-1:0]  RESULT_DATA,
  output logic                                            IRQ,
  output logic                                            BUSY,
  output logic [15:0]                                     RESULT_COUNT
);

  localparam int MID_W = mid_width(NUM_MACROS);
  localparam int NB_W  = 8 * NONCE_BYTES;
  localparam int RES_W = MID_W + NB_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(NONCE_BYTES + 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [MID_W-1:0]        r_ptr;
  logic [MID_W-1:0]        w_ptr_nxt;
  logic [NUM_MACROS-1:0]   r_armed;
  logic [NUM_MACROS-1:0]   r_sel;
  logic [HASH_ADDR_W-1:0]  r_addr;
  logic [IDX_W-1:0]        r_idx;
  logic [NB_W-1:0]         r_nonce;
  logic [15:0]             r_result_count;
  logic [NUM_MACROS-1:0]   w_onehot;
  logic                    w_cand;
  logic                    w_space;
  logic                    w_start;
  logic                    w_push;
  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_fifo_valid;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_MACROS; i++) w_onehot[i] = (r_ptr == MID_W'(i));
  end

  assign w_ptr_nxt = (r_ptr == MID_W'(NUM_MACROS - 1)) ? '0 : r_ptr + 1'b1;
  assign w_cand    = DATA_AVAILABLE[r_ptr] & ~MACRO_MASK[r_ptr] & r_armed[r_ptr];
  // Space is checked before the read starts so the later push always fits.
  assign w_space   = (w_fifo_count < CNT_W'(FIFO_DEPTH));
  assign w_start   = (r_state == ST_SCAN) & ENABLE & w_cand & w_space;
  assign w_push    = (r_state == ST_PUSH);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (ENABLE) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (!ENABLE)      w_state_nxt = ST_IDLE;
        else if (w_start) w_state_nxt = ST_READ;
      end
      ST_READ: if (r_idx == IDX_W'(NONCE_BYTES)) w_state_nxt = ST_PUSH;
      ST_PUSH: w_state_nxt = ENABLE ? ST_SCAN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ptr          <= '0;
      r_armed        <= '1;
      r_sel          <= '0;
      r_addr         <= '0;
      r_idx          <= '0;
      r_result_count <= '0;
    end else begin
      // A flag sampled low re-arms its macro; a flag held high is read once.
      r_armed <= (r_armed & ~(w_onehot & {NUM_MACROS{w_push}})) | ~DATA_AVAILABLE;
      case (r_state)
        ST_SCAN: begin
          if (w_start) begin
            r_sel  <= w_onehot;
            r_addr <= NONCE_BASE_ADDR;
            r_idx  <= '0;
          end else if (ENABLE) begin
            r_ptr <= w_ptr_nxt;
          end
        end
        ST_READ: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx < IDX_W'(NONCE_BYTES - 1))
            r_addr <= NONCE_BASE_ADDR + HASH_ADDR_W'(r_idx) + 1'b1;
          if (r_idx == IDX_W'(NONCE_BYTES)) r_sel <= '0;
        end
        ST_PUSH: begin
          r_ptr <= w_ptr_nxt;
          if (r_result_count != 16'hFFFF) r_result_count <= r_result_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bytes arrive LSB first; shifting in from the top leaves byte k at [8k+7:8k].
  always_ff @(posedge CLK) begin
    if ((r_state == ST_READ) && (r_idx != '0))
      r_nonce <= NB_W'({DATA_FROM_HASH, r_nonce} >> 8);
  end

  decred_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_push  (w_push),
    .i_data  ({r_ptr, r_nonce}),
    .i_pop   (RESULT_READY),
    .o_valid (w_fifo_valid),
    .o_data  (RESULT_DATA),
    .o_count (w_fifo_count)
  );

  assign MACRO_RD_SELECT = r_sel;
  assign HASH_ADDR       = r_addr;
  assign RESULT_VALID    = w_fifo_valid;
  assign IRQ             = w_fifo_valid;
  assign BUSY            = (r_state != ST_IDLE);
  assign RESULT_COUNT    = r_result_count;

endmodule

// File: tb/tb_decred_result_collector.sv
module tb_decred_result_collector;

  localparam int NM = 8;
  localparam int NB = 4;
  localparam int FD = 4;
  localparam int RW = 3 + 8 * NB;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          ENABLE = 1'b0;
  logic [NM-1:0] MACRO_MASK = '0;
  logic [NM-1:0] DATA_AVAILABLE = '0;
  logic [NM-1:0] MACRO_RD_SELECT;
  logic [5:0]    HASH_ADDR;
  logic [7:0]    DATA_FROM_HASH;
  logic          RESULT_VALID;
  logic          RESULT_READY = 1'b0;
  logic [RW-1:0] RESULT_DATA;
  logic          IRQ;
  logic          BUSY;
  logic [15:0]   RESULT_COUNT;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] nonce_mem [NM];

  always #5 CLK = ~CLK;

  decred_result_collector #(
    .NUM_MACROS      (NM),
    .NONCE_BYTES     (NB),
    .NONCE_BASE_ADDR (6'h00),
    .FIFO_DEPTH      (FD)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .ENABLE          (ENABLE),
    .MACRO_MASK      (MACRO_MASK),
    .DATA_AVAILABLE  (DATA_AVAILABLE),
    .MACRO_RD_SELECT (MACRO_RD_SELECT),
    .HASH_ADDR       (HASH_ADDR),
    .DATA_FROM_HASH  (DATA_FROM_HASH),
    .RESULT_VALID    (RESULT_VALID),
    .RESULT_READY    (RESULT_READY),
    .RESULT_DATA     (RESULT_DATA),
    .IRQ             (IRQ),
    .BUSY            (BUSY),
    .RESULT_COUNT    (RESULT_COUNT)
  );

  // Macro read port: registered, one cycle from address to data.
  function automatic logic [7:0] macro_byte(input logic [NM-1:0] sel, input logic [5:0] a);
    logic [7:0] d;
    int ai;
    d  = 8'hEE;
    ai = int'(a);
    for (int i = 0; i < NM; i++)
      if (sel[i]) d = (ai < NB) ? nonce_mem[i][8*ai +: 8] : 8'hFF;
    return d;
  endfunction

  always @(posedge CLK) DATA_FROM_HASH <= macro_byte(MACRO_RD_SELECT, HASH_ADDR);

  task automatic do_reset();
    RESET_N = 1'b0;
    ENABLE = 1'b0;
    DATA_AVAILABLE = '0;
    MACRO_MASK = '0;
    RESULT_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic wait_count(input logic [15:0] target, input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge CLK);
      if (RESULT_COUNT == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_head(output logic [RW-1:0] d, output bit had);
    had = RESULT_VALID;
    d = RESULT_DATA;
    RESULT_READY = 1'b1;
    @(negedge CLK);
    RESULT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    ENABLE = 1'b1;
    DATA_AVAILABLE = '1;
    repeat (3) @(negedge CLK);
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    vectors++; if (MACRO_RD_SELECT !== '0) begin miscompares++; $display("FAIL reset_sel: got %h want 00", MACRO_RD_SELECT); end
    vectors++; if (HASH_ADDR !== 6'd0) begin miscompares++; $display("FAIL reset_addr: got %h want 00", HASH_ADDR); end
    vectors++; if (RESULT_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", RESULT_VALID); end
    vectors++; if (IRQ !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    vectors++; if (RESULT_COUNT !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", RESULT_COUNT); end
    vectors++; if (RESULT_DATA !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", RESULT_DATA); end
    do_reset();
  endtask

  task automatic test_single_read();
    int lat;
    logic [RW-1:0] d;
    bit had;
    nonce_mem[2] = 32'h44332211;
    DATA_AVAILABLE = 8'h04;
    ENABLE = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (n == 4) begin
        vectors++; if (MACRO_RD_SELECT !== 8'h04) begin miscompares++; $display("FAIL single_sel_start: got %h want 04", MACRO_RD_SELECT); end
        vectors++; if (HASH_ADDR !== 6'd0) begin miscompares++; $display("FAIL single_addr0: got %h want 00", HASH_ADDR); end
      end
      if (n == 7) begin
        vectors++; if (HASH_ADDR !== 6'd3) begin miscompares++; $display("FAIL single_addr3: got %h want 03", HASH_ADDR); end
      end
      if (n == 8) begin
        vectors++; if (MACRO_RD_SELECT !== 8'h04) begin miscompares++; $display("FAIL single_sel_last: got %h want 04", MACRO_RD_SELECT); end
      end
      if (n == 9) begin
        vectors++; if (MACRO_RD_SELECT !== 8'h00) begin miscompares++; $display("FAIL single_sel_push: got %h want 00", MACRO_RD_SELECT); end
        vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", BUSY); end
      end
      if (RESULT_VALID === 1'b1) begin
        lat = n;
        break;
      end
    end
    vectors++; if (lat != 10) begin miscompares++; $display("FAIL single_latency: got %0d cycles want 10", lat); end
    vectors++; if (RESULT_DATA !== {3'd2, 32'h44332211}) begin miscompares++; $display("FAIL single_data: got %h want %h", RESULT_DATA, {3'd2, 32'h44332211}); end
    vectors++; if (IRQ !== 1'b1) begin miscompares++; $display("FAIL single_irq: got %b want 1", IRQ); end
    vectors++; if (RESULT_COUNT !== 16'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", RESULT_COUNT); end
    vectors++; if (HASH_ADDR !== 6'd3) begin miscompares++; $display("FAIL single_addr_hold: got %h want 03", HASH_ADDR); end
    DATA_AVAILABLE = '0;
    pop_head(d, had);
    vectors++; if (RESULT_VALID !== 1'b0 || IRQ !== 1'b0) begin miscompares++; $display("FAIL single_drained: got valid=%b irq=%b want 0/0", RESULT_VALID, IRQ); end
  endtask

  task automatic test_round_robin();
    bit ok;
    bit had;
    logic [RW-1:0] d;
    logic [RW-1:0] exp [4];
    do_reset();
    nonce_mem[0] = 32'hA0A1A2A3;
    nonce_mem[1] = 32'hB0B1B2B3;
    nonce_mem[3] = 32'hD0D1D2D3;
    exp[0] = {3'd0, 32'hA0A1A2A3};
    exp[1] = {3'd1, 32'hB0B1B2B3};
    exp[2] = {3'd3, 32'hD0D1D2D3};
    exp[3] = {3'd1, 32'hB0B1B2B3};
    DATA_AVAILABLE = 8'b0000_1011;
    ENABLE = 1'b1;
    wait_count(16'd2, 60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rr_first_two: count=%0d want 2", RESULT_COUNT); end
    DATA_AVAILABLE[1] = 1'b0;
    @(negedge CLK);
    DATA_AVAILABLE[1] = 1'b1;
    wait_count(16'd4, 80, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rr_four: count=%0d want 4", RESULT_COUNT); end
    for (int k = 0; k < 4; k++) begin
      pop_head(d, had);
      vectors++;
      if (!had || d !== exp[k]) begin
        miscompares++;
        $display("FAIL rr_order_%0d: got valid=%b data=%h want %h", k, had, d, exp[k]);
      end
    end
    repeat (20) @(negedge CLK);
    vectors++; if (RESULT_COUNT !== 16'd4 || RESULT_VALID !== 1'b0) begin miscompares++; $display("FAIL rr_no_reread: got count=%0d valid=%b want 4/0", RESULT_COUNT, RESULT_VALID); end
  endtask

  task automatic test_hold_once();
    bit ok;
    bit had;
    logic [RW-1:0] d;
    do_reset();
    nonce_mem[0] = 32'h0BADF00D;
    DATA_AVAILABLE = 8'h01;
    ENABLE = 1'b1;
    repeat (100) @(negedge CLK);
    vectors++; if (RESULT_COUNT !== 16'd1) begin miscompares++; $display("FAIL hold_count: got %0d want 1", RESULT_COUNT); end
    pop_head(d, had);
    vectors++; if (!had || d !== {3'd0, 32'h0BADF00D}) begin miscompares++; $display("FAIL hold_data: got valid=%b data=%h want %h", had, d, {3'd0, 32'h0BADF00D}); end
    vectors++; if (RESULT_VALID !== 1'b0) begin miscompares++; $display("FAIL hold_single: got valid=%b want 0", RESULT_VALID); end
    nonce_mem[0] = 32'hCAFEBABE;
    DATA_AVAILABLE = 8'h00;
    @(negedge CLK);
    DATA_AVAILABLE = 8'h01;
    wait_count(16'd2, 40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL hold_rearm: count=%0d want 2", RESULT_COUNT); end
    pop_head(d, had);
    vectors++; if (!had || d !== {3'd0, 32'hCAFEBABE}) begin miscompares++; $display("FAIL hold_rearm_data: got valid=%b data=%h want %h", had, d, {3'd0, 32'hCAFEBABE}); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit had;
    bit seen;
    int found;
    logic [RW-1:0] d;
    do_reset();
    for (int i = 0; i < NM; i++) nonce_mem[i] = 32'hC0DE0000 + i;
    DATA_AVAILABLE = 8'b0011_1111;
    ENABLE = 1'b1;
    wait_count(16'd4, 100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL full_fill: count=%0d want 4", RESULT_COUNT); end
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (MACRO_RD_SELECT != '0) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL full_no_read: got select activity while full, want none"); end
    vectors++; if (RESULT_COUNT !== 16'd4) begin miscompares++; $display("FAIL full_count: got %0d want 4", RESULT_COUNT); end
    pop_head(d, had);
    vectors++; if (!had || d !== {3'd0, 32'hC0DE0000}) begin miscompares++; $display("FAIL full_head: got valid=%b data=%h want %h", had, d, {3'd0, 32'hC0DE0000}); end
    found = -1;
    for (int n = 1; n <= NM + 1; n++) begin
      @(negedge CLK);
      if (MACRO_RD_SELECT != '0) begin
        found = n;
        break;
      end
    end
    vectors++; if (found < 0) begin miscompares++; $display("FAIL full_resume: no read within %0d cycles after pop", NM + 1); end
    vectors++; if (MACRO_RD_SELECT !== 8'h10 && MACRO_RD_SELECT !== 8'h20) begin miscompares++; $display("FAIL full_resume_sel: got %h want 10 or 20", MACRO_RD_SELECT); end
    RESULT_READY = 1'b1;
    wait_count(16'd6, 80, ok);
    RESULT_READY = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL full_all_six: count=%0d want 6", RESULT_COUNT); end
  endtask

  task automatic test_mask();
    bit ok;
    bit had;
    bit seen;
    logic [RW-1:0] d;
    do_reset();
    nonce_mem[1] = 32'h5A5A1234;
    MACRO_MASK = 8'h02;
    DATA_AVAILABLE = 8'h02;
    ENABLE = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (MACRO_RD_SELECT != '0) seen = 1'b1;
    end
    vectors++; if (seen || RESULT_COUNT !== 16'd0) begin miscompares++; $display("FAIL mask_blocks: got seen=%b count=%0d want 0/0", seen, RESULT_COUNT); end
    MACRO_MASK = 8'h00;
    wait_count(16'd1, 30, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL mask_release: count=%0d want 1", RESULT_COUNT); end
    pop_head(d, had);
    vectors++; if (!had || d !== {3'd1, 32'h5A5A1234}) begin miscompares++; $display("FAIL mask_data: got valid=%b data=%h want %h", had, d, {3'd1, 32'h5A5A1234}); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    bit found;
    logic [RW-1:0] d;
    bit had;
    do_reset();
    nonce_mem[2] = 32'h44332211;
    DATA_AVAILABLE = 8'h04;
    ENABLE = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (MACRO_RD_SELECT != '0 && HASH_ADDR == 6'd2) begin
        found = 1'b1;
        break;
      end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL midrst_reach: byte 2 address never driven"); end
    RESET_N = 1'b0;
    #1;
    vectors++; if (MACRO_RD_SELECT !== '0 || HASH_ADDR !== 6'd0) begin miscompares++; $display("FAIL midrst_bus: got sel=%h addr=%h want 00/00", MACRO_RD_SELECT, HASH_ADDR); end
    vectors++; if (BUSY !== 1'b0 || RESULT_VALID !== 1'b0 || IRQ !== 1'b0 || RESULT_COUNT !== 16'd0) begin miscompares++; $display("FAIL midrst_ctrl: got busy=%b valid=%b irq=%b count=%0d want all 0", BUSY, RESULT_VALID, IRQ, RESULT_COUNT); end
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_count(16'd1, 30, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_reread: count=%0d want 1", RESULT_COUNT); end
    pop_head(d, had);
    vectors++; if (!had || d !== {3'd2, 32'h44332211}) begin miscompares++; $display("FAIL midrst_data: got valid=%b data=%h want %h", had, d, {3'd2, 32'h44332211}); end
  endtask

  initial begin
    for (int i = 0; i < NM; i++) nonce_mem[i] = 32'h0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold_once();
    test_fifo_full();
    test_mask();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
